ex_stage_pipelined: RTL
=======================

Name: ex_stage_pipelined

Overview:
- Registered, parametrised execute stage. Sits between decode and writeback; replaces the combinational execute path.
- Adds a valid/ready handshake on both sides, a req/ack data-memory port with timeout, and a registered CPSR.
- Adds branch resolution and ASR.
- Results, flags and branch outcome are registered, one instruction in flight at a time.

Parameters:
- DATA_W, 32, datapath width (≥8, even).
- IMM_W, 16, immediate/offset width; sign-extended to DATA_W.
- REG_AW, 3, destination register index width.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before error (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept
- op_class  in  2  00 ALU, 01 MOVE/SHIFT, 10 MEM, 11 BRANCH
- op  in  3  operation within class
- use_imm  in  1  ALU operand 2 = sext(imm) instead of op2
- set_flags  in  1  ALU op updates CPSR
- b_cond  in  4  branch condition code
- dest_reg  in  REG_AW  writeback register index
- op1, op2  in  DATA_W  register operands
- imm  in  IMM_W  immediate / offset
- pc  in  DATA_W  PC of the instruction
- out_valid  out  1  result registers valid
- out_ready  in  1  downstream accepts
- wb_en  out  1  write result to dest
- wb_reg  out  REG_AW  registered dest_reg
- result  out  DATA_W  registered result
- br_taken  out  1  branch resolved taken
- br_target  out  DATA_W  pc + sext(imm)
- mem_err  out  1  memory timeout occurred for this instruction
- flags  out  4  CPSR {N,C,Z,V}
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  DATA_W  op1 + sext(imm)
- mem_wdata  out  DATA_W  op2
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  memory completes

Behaviour:
- Reset: all outputs 0, flags 4'b0000, FSM IDLE, timeout counter 0. Reset mid-memory-access drops mem_req the next cycle and discards the instruction.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept on in_valid && in_ready.
- Output registers hold stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new instruction completes the same cycle.
- FSM:
  - IDLE → RESP on accepting a non-MEM op: result computed and registered at the accept edge, out_valid=1 the next cycle (latency 1).
  - IDLE → MEM on accepting a MEM op: mem_req, mem_we, mem_addr and mem_wdata are registered at the accept edge.
  - MEM → RESP on mem_ack: load result = mem_rdata, wb_en=1; store wb_en=0.
  - MEM → RESP on timeout: counter reaches MEM_TIMEOUT without ack; mem_req drops, mem_err=1, wb_en=0, result=0.
  - RESP returns to IDLE when the output is consumed. RESP is represented by out_valid.
- mem_ack in the same cycle mem_req rises: ignored. Ack counts only while in MEM state.
- ALU (class 00), b = use_imm ? sext(imm) : op2:
  - 001 ADD: C = carry out; V = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB]).
  - 010 SUB: C = 1 when a ≥ b unsigned (no borrow); V = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB]).
  - 011 AND, 100 OR, 101 XOR, 110 NOT(op1): N and Z updated, C and V preserved.
  - 000, 111: result 0, wb_en=0.
  - wb_en=1 for valid ALU ops.
  - If set_flags: N = r[MSB], Z = (r==0). Flags register at the accept edge, so the next accepted instruction sees them.
- MOVE/SHIFT (class 01), wb_en=1; shift amount = imm[$clog2(DATA_W)-1:0]:
  - 000 MOV: low half = imm, upper half = op1.
  - 001 MOVT: upper half = imm, low half = op1.
  - 010 CLR: result 0.
  - 011 SET: result all ones.
  - 100 LSL, 101 LSR, 110 ASR: op1 shifted by the shift amount.
  - 111: wb_en=0.
  - Flags untouched.
- MEM (class 10): op 000 LOAD, 001 STORE. Any other op completes next cycle with wb_en=0, no request.
- BRANCH (class 11), wb_en=0, br_target always driven:
  - 000: unconditional, br_taken=1.
  - 001: br_taken per b_cond against current flags.
  - Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)); E AL 1; F never 0.
  - Other ops: br_taken=0.
- br_taken and mem_err are cleared for every instruction that does not set them.

Test Plan:
- Reset, then ADD: op1=0x7FFFFFFF, op2=1, use_imm=0, set_flags=1 → 1 cycle later result=0x80000000, flags=1001 (N,V), wb_en=1.
- SUB imm: op1=5, imm=16'h0005 → result 0, flags=0110 (C,Z). Then branch cond 0 (EQ) with pc=0x100, imm=16'hFFF0 → br_taken=1, br_target=0xF0.
- LOAD: op1=0x40, imm=4, mem_ack after 3 cycles with rdata=0xDEADBEEF → mem_addr=0x44 while mem_req held, result=0xDEADBEEF, wb_en=1, in_ready low throughout.
- STORE with no ack → after MEM_TIMEOUT cycles mem_req drops, mem_err=1, wb_en=0.
- Backpressure: out_ready=0 for 4 cycles after an ASR (op1=0x80000000, shamt 4) → result 0xF8000000 held stable, in_ready=0. Release → next instruction accepted that same cycle.
- Assert rst during MEM wait → mem_req=0, out_valid=0 and flags=0 the next cycle.

Source files
------------

// File: rtl/ex_stage_pipelined.sv
// Registered execute stage: ALU, move/shift, data-memory access with timeout and branch resolution.
// One instruction in flight; result, CPSR and branch outcome are held in output registers.
module ex_stage_pipelined #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IMM_W       = 16,
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_class,
  input  logic [2:0]        op,
  input  logic              use_imm,
  input  logic              set_flags,
  input  logic [3:0]        b_cond,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] result,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target,
  output logic              mem_err,
  output logic [3:0]        flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned SH_W   = $clog2(DATA_W);
  localparam int unsigned CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned MSB    = DATA_W - 1;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_MOVE   = 2'b01;
  localparam logic [1:0] CLS_MEM    = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  // CPSR bit positions within {N,C,Z,V}
  localparam int unsigned F_N = 3;
  localparam int unsigned F_C = 2;
  localparam int unsigned F_Z = 1;
  localparam int unsigned F_V = 0;

  typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_AW-1:0]   wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                br_taken_q, br_taken_d;
  logic [DATA_W-1:0]   br_target_q, br_target_d;
  logic                mem_err_q, mem_err_d;
  logic [3:0]          flags_q, flags_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [DATA_W-1:0]   imm_sext;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W:0]     add_w;
  logic [DATA_W-1:0]   sub_w;
  logic [SH_W-1:0]     shamt;
  logic                accept;
  logic                is_mem_access;

  logic [DATA_W-1:0]   alu_r;
  logic                alu_ok, alu_arith, alu_c, alu_v;
  logic [DATA_W-1:0]   exec_result;
  logic                exec_wb, exec_br;
  logic [3:0]          exec_flags;

  function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] f);
    logic n, c, z, v;
    n = f[F_N];
    c = f[F_C];
    z = f[F_Z];
    v = f[F_V];
    case (cc)
      4'h0:    cond_met = z;
      4'h1:    cond_met = !z;
      4'h2:    cond_met = c;
      4'h3:    cond_met = !c;
      4'h4:    cond_met = n;
      4'h5:    cond_met = !n;
      4'h6:    cond_met = v;
      4'h7:    cond_met = !v;
      4'h8:    cond_met = c && !z;
      4'h9:    cond_met = !(c && !z);
      4'hA:    cond_met = (n == v);
      4'hB:    cond_met = (n != v);
      4'hC:    cond_met = !z && (n == v);
      4'hD:    cond_met = !(!z && (n == v));
      4'hE:    cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign imm_sext      = DATA_W'($signed(imm));
  assign alu_b         = use_imm ? imm_sext : op2;
  assign add_w         = {1'b0, op1} + {1'b0, alu_b};
  assign sub_w         = op1 - alu_b;
  assign shamt         = imm[SH_W-1:0];
  assign in_ready      = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept        = in_valid && in_ready;
  assign is_mem_access = (op_class == CLS_MEM) && ((op == 3'b000) || (op == 3'b001));

  // Single-cycle result for every non-memory instruction
  always_comb begin
    alu_r       = '0;
    alu_ok      = 1'b1;
    alu_arith   = 1'b0;
    alu_c       = flags_q[F_C];
    alu_v       = flags_q[F_V];
    exec_result = '0;
    exec_wb     = 1'b0;
    exec_br     = 1'b0;
    exec_flags  = flags_q;
    case (op_class)
      CLS_ALU: begin
        case (op)
          3'b001: begin
            alu_r     = add_w[DATA_W-1:0];
            alu_arith = 1'b1;
            alu_c     = add_w[DATA_W];
            alu_v     = (op1[MSB] == alu_b[MSB]) && (alu_r[MSB] != op1[MSB]);
          end
          3'b010: begin
            alu_r     = sub_w;
            alu_arith = 1'b1;
            alu_c     = (op1 >= alu_b);
            alu_v     = (op1[MSB] != alu_b[MSB]) && (alu_r[MSB] != op1[MSB]);
          end
          3'b011:  alu_r = op1 & alu_b;
          3'b100:  alu_r = op1 | alu_b;
          3'b101:  alu_r = op1 ^ alu_b;
          3'b110:  alu_r = ~op1;
          default: alu_ok = 1'b0;
        endcase
        if (alu_ok) begin
          exec_result = alu_r;
          exec_wb     = 1'b1;
          if (set_flags) begin
            exec_flags[F_N] = alu_r[MSB];
            exec_flags[F_Z] = (alu_r == '0);
            if (alu_arith) begin
              exec_flags[F_C] = alu_c;
              exec_flags[F_V] = alu_v;
            end
          end
        end
      end
      CLS_MOVE: begin
        exec_wb = 1'b1;
        case (op)
          3'b000:  exec_result = {op1[DATA_W-1:HALF_W], HALF_W'(imm)};
          3'b001:  exec_result = {HALF_W'(imm), op1[HALF_W-1:0]};
          3'b010:  exec_result = '0;
          3'b011:  exec_result = '1;
          3'b100:  exec_result = op1 << shamt;
          3'b101:  exec_result = op1 >> shamt;
          3'b110:  exec_result = DATA_W'($signed(op1) >>> shamt);
          default: exec_wb = 1'b0;
        endcase
      end
      CLS_BRANCH: begin
        case (op)
          3'b000:  exec_br = 1'b1;
          3'b001:  exec_br = cond_met(b_cond, flags_q);
          default: exec_br = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state: accept, memory wait with timeout, output hold/consume
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    wb_en_d     = wb_en_q;
    wb_reg_d    = wb_reg_q;
    result_d    = result_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    mem_err_d   = mem_err_q;
    flags_d     = flags_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wb_reg_d    = dest_reg;
          br_target_d = pc + imm_sext;
          if (is_mem_access) begin
            state_d     = S_MEM;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = op[0];
            mem_addr_d  = op1 + imm_sext;
            mem_wdata_d = op2;
          end else begin
            out_valid_d = 1'b1;
            result_d    = exec_result;
            wb_en_d     = exec_wb;
            br_taken_d  = exec_br;
            mem_err_d   = 1'b0;
            flags_d     = exec_flags;
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          result_d    = mem_we_q ? '0 : mem_rdata;
          wb_en_d     = !mem_we_q;
          br_taken_d  = 1'b0;
          mem_err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          result_d    = '0;
          wb_en_d     = 1'b0;
          br_taken_d  = 1'b0;
          mem_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      result_q    <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      mem_err_q   <= 1'b0;
      flags_q     <= 4'b0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      result_q    <= result_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      mem_err_q   <= mem_err_d;
      flags_q     <= flags_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign out_valid = out_valid_q;
  assign wb_en     = wb_en_q;
  assign wb_reg    = wb_reg_q;
  assign result    = result_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign mem_err   = mem_err_q;
  assign flags     = flags_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
